// File: rtl/jpeg_idct_transpose_rd.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_idct_transpose_rd
//  Description : Column-major reader for the IDCT ping-pong transpose RAM.
//                Streams a full bank to the column pass and hands it back.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_idct_transpose_rd #(
   parameter int SAMPLE_W = 16,
   parameter int BLK_N    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            bank_valid_i,
   output logic [1:0]            bank_release_o,
   output logic                  rd0_o,
   output logic                  rd1_o,
   output logic [4:0]            addr0_o,
   output logic [4:0]            addr1_o,
   input  logic [2*SAMPLE_W-1:0] data0_i,
   input  logic [2*SAMPLE_W-1:0] data1_i,
   output logic                  outport_valid_o,
   output logic [SAMPLE_W-1:0]   outport_data_o,
   output logic [5:0]            outport_idx_o,
   output logic                  outport_last_o,
   input  logic                  outport_accept_i
);

   localparam logic [5:0] c_LAST_BEAT = 6'(BLK_N * BLK_N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_DRAIN   = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_ptr;
   logic [5:0]          r_beat;
   logic [1:0]          r_release;

   logic                r_pend;
   logic                r_pend_half;
   logic [5:0]          r_pend_idx;
   logic                r_pend_last;

   logic [SAMPLE_W-1:0] r_fifo_data [2];
   logic [5:0]          r_fifo_idx  [2];
   logic                r_fifo_last [2];
   logic                r_wr_sel;
   logic                r_rd_sel;
   logic [1:0]          r_cnt;

   logic                  w_pop;
   logic [2:0]            w_used;
   logic                  w_issue;
   logic [4:0]            w_addr;
   logic [2*SAMPLE_W-1:0] w_rdata;
   logic [SAMPLE_W-1:0]   w_sample;
   logic                  w_head_last;

   // A slot freed by this cycle's pop is reusable, which keeps full throughput
   // while never letting buffered plus in-flight samples exceed two.
   assign w_pop       = (r_cnt != 2'd0) && outport_accept_i;
   assign w_used      = {1'b0, r_cnt} + {2'b00, r_pend};
   assign w_issue     = (r_state == S_READ) && (w_used < (3'd2 + {2'b00, w_pop}));
   assign w_addr      = {r_beat[2:0], r_beat[5:4]};
   assign w_rdata     = r_ptr ? data1_i : data0_i;
   assign w_sample    = r_pend_half ? w_rdata[2*SAMPLE_W-1:SAMPLE_W] : w_rdata[SAMPLE_W-1:0];
   assign w_head_last = r_fifo_last[r_rd_sel];

   assign rd0_o   = w_issue && !r_ptr;
   assign rd1_o   = w_issue &&  r_ptr;
   assign addr0_o = rd0_o ? w_addr : 5'd0;
   assign addr1_o = rd1_o ? w_addr : 5'd0;

   assign bank_release_o  = r_release;
   assign outport_valid_o = (r_cnt != 2'd0);
   assign outport_data_o  = r_fifo_data[r_rd_sel];
   assign outport_idx_o   = r_fifo_idx[r_rd_sel];
   assign outport_last_o  = w_head_last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_ptr     <= 1'b0;
         r_beat    <= 6'd0;
         r_release <= 2'b00;
      end else begin
         r_release <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (bank_valid_i[r_ptr]) begin
                  r_state <= S_READ;
                  r_beat  <= 6'd0;
               end
            end
            S_READ: begin
               if (w_issue) begin
                  if (r_beat == c_LAST_BEAT) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_beat <= r_beat + 6'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (!r_pend && (r_cnt == 2'd1) && w_pop && w_head_last) begin
                  r_state   <= S_RELEASE;
                  r_release <= r_ptr ? 2'b10 : 2'b01;
               end
            end
            S_RELEASE: begin
               // Going straight to READ lets the other bank start one cycle sooner.
               r_ptr  <= ~r_ptr;
               r_beat <= 6'd0;
               if (bank_valid_i[~r_ptr]) begin
                  r_state <= S_READ;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend      <= 1'b0;
         r_pend_half <= 1'b0;
         r_pend_idx  <= 6'd0;
         r_pend_last <= 1'b0;
         r_wr_sel    <= 1'b0;
         r_rd_sel    <= 1'b0;
         r_cnt       <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_idx[i]  <= 6'd0;
            r_fifo_last[i] <= 1'b0;
         end
      end else begin
         r_pend      <= w_issue;
         r_pend_half <= r_beat[3];
         r_pend_idx  <= r_beat;
         r_pend_last <= (r_beat == c_LAST_BEAT);
         if (r_pend) begin
            r_fifo_data[r_wr_sel] <= w_sample;
            r_fifo_idx[r_wr_sel]  <= r_pend_idx;
            r_fifo_last[r_wr_sel] <= r_pend_last;
            r_wr_sel              <= ~r_wr_sel;
         end
         if (w_pop) begin
            r_rd_sel <= ~r_rd_sel;
         end
         r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      end
   end

endmodule
`default_nettype wire
